// File: rtl/convolver_ctrl.sv
// convolver_ctrl: 3x3 convolver lane sequencer (ports: clk, rst async active-low, start/abort, row_length/num_rows, flt/pix handshakes, shifting_*, line_buffer_reset, mac_enable, out_valid, busy, done, cfg_err)
module convolver_ctrl #(
  parameter int ROW_W   = 10,
  parameter int MAC_LAT = 2,
  parameter int TAPS    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] row_length,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             flt_valid,
  output logic             flt_ready,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             shifting_filter,
  output logic             line_buffer_reset,
  output logic             shifting_line,
  output logic             mac_enable,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  localparam int CW = $clog2(TAPS + MAC_LAT + 1);
  typedef enum logic [1:0] {IDLE, LOADF, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [ROW_W-1:0] w, h, col, row;
  logic [CW-1:0] cnt;
  logic [MAC_LAT-1:0] pipe;
  logic cfg_ok, start_ok, tap_last, pix_last, drain_last, col_last;
  assign flt_ready       = state == LOADF;
  assign pix_ready       = state == STREAM;
  assign busy            = state != IDLE;
  assign shifting_filter = flt_valid & flt_ready;
  assign shifting_line   = pix_valid & pix_ready;
  assign out_valid       = pipe[MAC_LAT-1];
  assign cfg_ok          = row_length >= ROW_W'(3) && num_rows >= ROW_W'(3);
  assign start_ok        = state == IDLE && start && !abort && cfg_ok;
  assign tap_last        = shifting_filter && cnt == CW'(TAPS - 1);
  assign col_last        = col == w - ROW_W'(1);
  assign pix_last        = shifting_line && col_last && row == h - ROW_W'(1);
  assign drain_last      = state == DRAIN && cnt == CW'(MAC_LAT);
  assign done            = drain_last;
  always_comb begin
    state_n = abort ? IDLE : start_ok ? LOADF : tap_last ? STREAM : pix_last ? DRAIN : drain_last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      w                 <= '0;
      h                 <= '0;
      col               <= '0;
      row               <= '0;
      line_buffer_reset <= 1'b0;
      cfg_err           <= 1'b0;
      mac_enable        <= 1'b0;
      pipe              <= '0;
    end else begin
      state             <= state_n;
      cnt               <= (state_n != state) ? '0 : (shifting_filter || state == DRAIN) ? cnt + CW'(1) : cnt;
      w                 <= start_ok ? row_length : w;
      h                 <= start_ok ? num_rows : h;
      col               <= start_ok ? '0 : shifting_line ? (col_last ? '0 : col + ROW_W'(1)) : col;
      row               <= start_ok ? '0 : (shifting_line && col_last) ? row + ROW_W'(1) : row;
      line_buffer_reset <= start_ok || (abort && state != IDLE);
      cfg_err           <= state == IDLE && start && !abort && !cfg_ok;
      // window is valid once two full rows and two columns of the current row are buffered
      mac_enable        <= !abort && shifting_line && row >= ROW_W'(2) && col >= ROW_W'(2);
      pipe              <= abort ? '0 : MAC_LAT'({pipe, mac_enable});
    end
  end
endmodule

// File: tb/tb_convolver_ctrl.sv
// tb_convolver_ctrl: randomized bench with behavioural schedule model for convolver_ctrl
module tb_convolver_ctrl;
  localparam int LAT = 2;
  logic clk = 0, rst = 0, start = 0, abort = 0, flt_valid = 0, pix_valid = 0;
  logic [9:0] row_length = 0, num_rows = 0;
  logic flt_ready, pix_ready, shifting_filter, line_buffer_reset, shifting_line;
  logic mac_enable, out_valid, busy, done, cfg_err;
  logic [9:0] outs;
  int vectors = 0, miscompares = 0, cyc = 0;
  int mphase = 0, mw = 0, mh = 0, taps = 0, pix = 0, drain_end = 0;
  bit lbr_q[16], mac_q[16], ov_q[16], dn_q[16], cfg_q[16];
  int n_sf, n_sl, n_lbr, n_mac, n_ov, n_done, n_cfg, n_busy, first_mac, sl13, last_ov, done_cyc, min_gap;
  int fv_mode = 0, pv_mode = 0;
  bit tog = 1;
  convolver_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .row_length(row_length), .num_rows(num_rows),
    .flt_valid(flt_valid), .flt_ready(flt_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .shifting_filter(shifting_filter), .line_buffer_reset(line_buffer_reset),
    .shifting_line(shifting_line), .mac_enable(mac_enable), .out_valid(out_valid),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  assign outs = {flt_ready, pix_ready, shifting_filter, line_buffer_reset, shifting_line,
                 mac_enable, out_valid, busy, done, cfg_err};
  always #5 clk = ~clk;
  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      lbr_q[i] = 0; mac_q[i] = 0; ov_q[i] = 0; dn_q[i] = 0; cfg_q[i] = 0;
    end
  endtask
  always @(negedge clk) begin
    logic [9:0] e;
    int s, n1;
    s  = cyc % 16;
    n1 = (cyc + 1) % 16;
    if (!rst) begin
      mphase = 0;
      clear_model();
    end
    e = {mphase == 1, mphase == 2, mphase == 1 && flt_valid, lbr_q[s], mphase == 2 && pix_valid,
         mac_q[s], ov_q[s], mphase != 0, dn_q[s], cfg_q[s]};
    vectors++;
    if (outs !== e) begin
      miscompares++;
      $display("FAIL outputs cyc=%0d got %b expected %b (ready_f ready_p sh_f lbr sh_l mac ov busy done cfg)", cyc, outs, e);
    end
    n_sf += int'(shifting_filter); n_lbr += int'(line_buffer_reset); n_mac += int'(mac_enable);
    n_done += int'(done); n_cfg += int'(cfg_err); n_busy += int'(busy);
    if (shifting_line) begin
      n_sl++;
      if (n_sl == 13) sl13 = cyc;
    end
    if (mac_enable && first_mac < 0) first_mac = cyc;
    if (out_valid) begin
      n_ov++;
      if (cyc - last_ov < min_gap) min_gap = cyc - last_ov;
      last_ov = cyc;
    end
    if (done) done_cyc = cyc;
    if (rst) begin
      lbr_q[s] = 0; mac_q[s] = 0; ov_q[s] = 0; dn_q[s] = 0; cfg_q[s] = 0;
      if (abort && mphase != 0) begin
        clear_model();
        mphase = 0;
        lbr_q[n1] = 1;
      end else if (!abort) begin
        case (mphase)
          0: if (start) begin
               if (row_length >= 3 && num_rows >= 3) begin
                 mw = int'(row_length); mh = int'(num_rows); taps = 0; mphase = 1; lbr_q[n1] = 1;
               end else cfg_q[n1] = 1;
             end
          1: if (flt_valid) begin
               taps++;
               if (taps == 9) begin mphase = 2; pix = 0; end
             end
          2: if (pix_valid) begin
               if (pix / mw >= 2 && pix % mw >= 2) begin
                 mac_q[n1] = 1;
                 ov_q[(cyc + 1 + LAT) % 16] = 1;
               end
               pix++;
               if (pix == mw * mh) begin
                 mphase = 3;
                 drain_end = cyc + 1 + LAT;
                 dn_q[drain_end % 16] = 1;
               end
             end
          default: if (cyc == drain_end) mphase = 0;
        endcase
      end
    end
    cyc++;
  end
  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic clr_counts();
    n_sf = 0; n_sl = 0; n_lbr = 0; n_mac = 0; n_ov = 0; n_done = 0; n_cfg = 0; n_busy = 0;
    first_mac = -1; sl13 = -1; last_ov = -1000; done_cyc = -1; min_gap = 1000;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    flt_valid = fv_mode != 0 ? ($urandom % 2) == 1 : 1'b1;
    pix_valid = pv_mode == 1 ? tog : pv_mode == 2 ? ($urandom % 4) != 0 : 1'b1;
    tog = !tog;
  endtask
  task automatic run_plane(int w, int h, bit extra, bit rnd_abort);
    int k;
    clr_counts();
    row_length = 10'(w); num_rows = 10'(h);
    start = 1; step(); start = 0;
    k = 0;
    while (mphase != 0 && k < 2000) begin
      start = extra && (k == 3 || k == 15);
      abort = rnd_abort && ($urandom % 150) == 0;
      step();
      k++;
    end
    start = 0; abort = 0;
    chk("plane_timeout", int'(k < 2000), 1);
    repeat (3) step();
  endtask
  initial begin
    int k;
    clr_counts();
    repeat (3) step();
    chk("reset_outs", int'(outs), 0);
    rst = 1;
    step();
    // case 1: all valids high
    run_plane(5, 4, 0, 0);
    chk("c1_sf", n_sf, 9); chk("c1_sl", n_sl, 20); chk("c1_lbr", n_lbr, 1);
    chk("c1_mac", n_mac, 6); chk("c1_ov", n_ov, 6); chk("c1_done", n_done, 1);
    chk("c1_first_mac_after_px12", first_mac - sl13, 1);
    chk("c1_done_with_last_ov", done_cyc - last_ov, 0);
    // case 2: pix_valid toggling
    pv_mode = 1;
    run_plane(5, 4, 0, 0);
    chk("c2_ov", n_ov, 6); chk("c2_done", n_done, 1); chk("c2_sl", n_sl, 20);
    chk("c2_ov_gap_ge2", int'(min_gap >= 2), 1);
    // case 3: rejected config
    pv_mode = 0;
    run_plane(2, 8, 0, 0);
    chk("c3_cfg", n_cfg, 1); chk("c3_busy", n_busy, 0); chk("c3_activity", n_sf + n_sl + n_lbr, 0);
    // case 4: abort after pixel 7
    clr_counts();
    row_length = 5; num_rows = 4;
    start = 1; step(); start = 0;
    k = 0;
    while (n_sl < 7 && k < 200) begin step(); k++; end
    chk("c4_wait_px7", int'(k < 200), 1);
    abort = 1; step(); abort = 0;
    n_lbr = 0; n_ov = 0; n_done = 0;
    repeat (20) step();
    chk("c4_lbr", n_lbr, 1); chk("c4_ov", n_ov, 0); chk("c4_done", n_done, 0); chk("c4_busy", int'(busy), 0);
    run_plane(5, 4, 0, 0);
    chk("c4_restart_ov", n_ov, 6); chk("c4_restart_done", n_done, 1);
    // case 5: async reset mid-stream
    clr_counts();
    row_length = 5; num_rows = 4;
    start = 1; step(); start = 0;
    k = 0;
    while (n_sl < 5 && k < 200) begin step(); k++; end
    chk("c5_wait_px5", int'(k < 200), 1);
    @(posedge clk);
    #3 rst = 0;
    #1 chk("c5_async_outs", int'(outs), 0);
    repeat (2) step();
    rst = 1;
    step();
    run_plane(5, 4, 0, 0);
    chk("c5_sf", n_sf, 9); chk("c5_sl", n_sl, 20); chk("c5_ov", n_ov, 6); chk("c5_done", n_done, 1);
    // case 6: extra starts while busy
    run_plane(5, 4, 1, 0);
    chk("c6_ov", n_ov, 6); chk("c6_done", n_done, 1); chk("c6_lbr", n_lbr, 1); chk("c6_cfg", n_cfg, 0);
    // randomized planes with random valids, starts and aborts
    fv_mode = 1; pv_mode = 2;
    repeat (40) run_plane(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), ($urandom % 2) == 1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
